// File: rtl/conv_weight_bank.sv
`default_nettype none
// ============================================================================
// Module      : conv_weight_bank
// Description : Kernel weight/bias store streamed out one word per SHIFT/BIAS cycle.
// Revision    : 1.0
// ============================================================================
module conv_weight_bank #(
    parameter  int DATA_WIDTH  = 32,
    parameter  int KERNEL_SIZE = 3,
    parameter  int NUM_SETS    = 4,
    localparam int SET_DEPTH   = KERNEL_SIZE * KERNEL_SIZE + 1,
    localparam int DEPTH       = NUM_SETS * SET_DEPTH,
    localparam int ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int SET_W       = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            current_state,
    input  logic [SET_W-1:0]      i_set_base,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_weight,
    output logic                  o_weight_valid,
    output logic                  o_is_bias,
    output logic [SET_W-1:0]      o_set_idx,
    output logic                  o_set_done,
    output logic                  o_wr_err
);

    localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int OFF_W = (SET_DEPTH > 1) ? $clog2(SET_DEPTH) : 1;

    localparam logic [2:0] ST_INIT    = 3'd0;
    localparam logic [2:0] ST_PRELOAD = 3'd1;
    localparam logic [2:0] ST_SHIFT   = 3'd2;
    localparam logic [2:0] ST_BIAS    = 3'd5;
    localparam logic [2:0] ST_LOAD    = 3'd6;

    localparam logic [ADDR_W:0]   C_DEPTH    = (ADDR_W + 1)'(DEPTH);
    localparam logic [OFF_W-1:0]  C_LAST_OFF = OFF_W'(KK - 1);
    localparam logic [SET_W-1:0]  C_LAST_SET = SET_W'(NUM_SETS - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [OFF_W-1:0]      r_offset;
    logic [SET_W-1:0]      r_set_idx;
    logic [2:0]            r_prev_state;
    logic [DATA_WIDTH-1:0] r_weight;
    logic                  r_weight_valid;
    logic                  r_is_bias;
    logic                  r_set_done;
    logic                  r_wr_err;

    logic                  w_is_init;
    logic                  w_is_preload;
    logic                  w_is_shift;
    logic                  w_is_bias;
    logic                  w_is_load;
    logic                  w_is_idle;
    logic                  w_wr_accept;
    logic                  w_wr_reject;
    logic [ADDR_W-1:0]     w_base_addr;
    logic [ADDR_W-1:0]     w_shift_addr;
    logic [ADDR_W-1:0]     w_bias_addr;

    // Unlisted state codes fall into IDLE behaviour.
    assign w_is_init    = (current_state == ST_INIT);
    assign w_is_preload = (current_state == ST_PRELOAD);
    assign w_is_shift   = (current_state == ST_SHIFT);
    assign w_is_bias    = (current_state == ST_BIAS);
    assign w_is_load    = (current_state == ST_LOAD);
    assign w_is_idle    = ~(w_is_init | w_is_preload | w_is_shift | w_is_bias | w_is_load);

    assign w_wr_accept  = i_wr_en & (w_is_init | w_is_idle) & ({1'b0, i_wr_addr} < C_DEPTH);
    assign w_wr_reject  = i_wr_en & ~w_wr_accept;

    assign w_base_addr  = ADDR_W'(int'(r_set_idx) * SET_DEPTH);
    assign w_shift_addr = w_base_addr + ADDR_W'(r_offset);
    assign w_bias_addr  = w_base_addr + ADDR_W'(KK);

    // Weight storage carries no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_offset       <= '0;
            r_set_idx      <= '0;
            r_prev_state   <= ST_INIT;
            r_weight       <= '0;
            r_weight_valid <= 1'b0;
            r_is_bias      <= 1'b0;
            r_set_done     <= 1'b0;
            r_wr_err       <= 1'b0;
        end else begin
            r_prev_state   <= current_state;
            r_wr_err       <= w_wr_reject;
            r_set_done     <= w_is_bias && (r_prev_state != ST_BIAS);
            r_weight       <= '0;
            r_weight_valid <= 1'b0;
            r_is_bias      <= 1'b0;

            if (w_is_shift) begin
                r_weight       <= r_mem[w_shift_addr];
                r_weight_valid <= 1'b1;
                r_offset       <= (r_offset == C_LAST_OFF) ? '0 : r_offset + OFF_W'(1);
            end else if (w_is_bias) begin
                r_weight       <= r_mem[w_bias_addr];
                r_weight_valid <= 1'b1;
                r_is_bias      <= 1'b1;
                r_offset       <= '0;
            end else if (w_is_preload) begin
                r_offset  <= '0;
                r_set_idx <= (int'(i_set_base) < NUM_SETS) ? i_set_base : '0;
            end else if (w_is_load) begin
                r_offset <= '0;
                // Only the LOAD that directly follows a bias moves on to the next set.
                if (r_prev_state == ST_BIAS) begin
                    r_set_idx <= (r_set_idx == C_LAST_SET) ? '0 : r_set_idx + SET_W'(1);
                end
            end else if (w_is_init) begin
                r_offset  <= '0;
                r_set_idx <= '0;
            end
        end
    end

    assign o_weight       = r_weight;
    assign o_weight_valid = r_weight_valid;
    assign o_is_bias      = r_is_bias;
    assign o_set_idx      = r_set_idx;
    assign o_set_done     = r_set_done;
    assign o_wr_err       = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_weight_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_weight_bank
// Description : Directed-vector scoreboard bench for conv_weight_bank.
// Revision    : 1.0
// ============================================================================
module tb_conv_weight_bank;

    localparam logic [2:0] ST_INIT    = 3'd0;
    localparam logic [2:0] ST_PRELOAD = 3'd1;
    localparam logic [2:0] ST_SHIFT   = 3'd2;
    localparam logic [2:0] ST_BIAS    = 3'd5;
    localparam logic [2:0] ST_LOAD    = 3'd6;
    localparam logic [2:0] ST_IDLE    = 3'd7;

    logic        clk;
    logic        rst_n;
    logic [2:0]  current_state;
    logic [1:0]  i_set_base;
    logic        i_wr_en;
    logic [5:0]  i_wr_addr;
    logic [31:0] i_wr_data;
    logic [31:0] o_weight;
    logic        o_weight_valid;
    logic        o_is_bias;
    logic [1:0]  o_set_idx;
    logic        o_set_done;
    logic        o_wr_err;

    typedef struct {
        logic [31:0] w;
        logic        bias;
        logic        done;
        logic [1:0]  set;
    } exp_t;

    exp_t q[$];
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   n_err_obs = 0;

    conv_weight_bank #(
        .DATA_WIDTH (32),
        .KERNEL_SIZE(3),
        .NUM_SETS   (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .current_state (current_state),
        .i_set_base    (i_set_base),
        .i_wr_en       (i_wr_en),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .o_weight      (o_weight),
        .o_weight_valid(o_weight_valid),
        .o_is_bias     (o_is_bias),
        .o_set_idx     (o_set_idx),
        .o_set_done    (o_set_done),
        .o_wr_err      (o_wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [2:0] st);
        current_state = st;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w, input logic bias, input logic done, input logic [1:0] set);
        exp_t e;
        e.w = w; e.bias = bias; e.done = done; e.set = set;
        q.push_back(e);
    endtask

    task automatic shift_exp(input logic [31:0] w, input logic [1:0] set);
        push(w, 1'b0, 1'b0, set);
        cyc(ST_SHIFT);
    endtask

    task automatic bias_exp(input logic [31:0] w, input logic done, input logic [1:0] set);
        push(w, 1'b1, done, set);
        cyc(ST_BIAS);
    endtask

    task automatic preload(input logic [1:0] base);
        i_set_base = base;
        cyc(ST_PRELOAD);
    endtask

    task automatic wr_cyc(input logic [2:0] st, input logic [5:0] addr, input logic [31:0] data);
        i_wr_en   = 1'b1;
        i_wr_addr = addr;
        i_wr_data = data;
        cyc(st);
        i_wr_en   = 1'b0;
    endtask

    // Monitor: pops one expectation per presented word, checks quiet outputs otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_wr_err) n_err_obs++;
            if (o_weight_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got %0d expected no output", o_weight);
                end else begin
                    e = q.pop_front();
                    chk("weight",   64'(o_weight),   64'(e.w));
                    chk("is_bias",  64'(o_is_bias),  64'(e.bias));
                    chk("set_done", 64'(o_set_done), 64'(e.done));
                    chk("set_idx",  64'(o_set_idx),  64'(e.set));
                end
            end else begin
                chk("quiet_weight", 64'(o_weight),   64'd0);
                chk("quiet_bias",   64'(o_is_bias),  64'd0);
                chk("quiet_done",   64'(o_set_done), 64'd0);
            end
        end
    end

    initial begin
        current_state = ST_IDLE;
        i_set_base    = '0;
        i_wr_en       = 1'b0;
        i_wr_addr     = '0;
        i_wr_data     = '0;
        rst_n         = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_weight", 64'(o_weight),       64'd0);
        chk("rst_valid",  64'(o_weight_valid), 64'd0);
        chk("rst_bias",   64'(o_is_bias),      64'd0);
        chk("rst_done",   64'(o_set_done),     64'd0);
        chk("rst_wr_err", 64'(o_wr_err),       64'd0);
        chk("rst_set",    64'(o_set_idx),      64'd0);
        rst_n = 1'b1;

        for (int a = 0; a < 40; a++) wr_cyc(ST_IDLE, 6'(a), 32'(a + 100));
        chk("fill_no_err", 64'(o_wr_err), 64'd0);

        // Set 1: nine weights then its bias.
        preload(2'd1);
        for (int k = 0; k < 9; k++) shift_exp(32'(110 + k), 2'd1);
        bias_exp(32'd119, 1'b1, 2'd1);
        cyc(ST_IDLE);

        // Set 0: offset wraps after 8.
        preload(2'd0);
        for (int k = 0; k < 11; k++) shift_exp(32'(100 + (k % 9)), 2'd0);
        cyc(ST_IDLE);

        // Repeated bias pulses done only once.
        preload(2'd2);
        bias_exp(32'd129, 1'b1, 2'd2);
        bias_exp(32'd129, 1'b0, 2'd2);
        bias_exp(32'd129, 1'b0, 2'd2);
        cyc(ST_IDLE);

        // Set advance on LOAD after BIAS, including wrap 3 -> 0.
        preload(2'd3);
        bias_exp(32'd139, 1'b1, 2'd3);
        cyc(ST_LOAD);
        shift_exp(32'd100, 2'd0);
        cyc(ST_IDLE);
        preload(2'd1);
        bias_exp(32'd119, 1'b1, 2'd1);
        cyc(ST_LOAD);
        shift_exp(32'd120, 2'd2);
        cyc(ST_IDLE);
        cyc(ST_LOAD);
        shift_exp(32'd120, 2'd2);
        cyc(ST_IDLE);

        // Rejected writes: in SHIFT, and out of range in IDLE.
        preload(2'd1);
        push(32'd110, 1'b0, 1'b0, 2'd1);
        wr_cyc(ST_SHIFT, 6'd12, 32'hDEAD);
        chk("wr_err_shift", 64'(o_wr_err), 64'd1);
        shift_exp(32'd111, 2'd1);
        chk("wr_err_clear1", 64'(o_wr_err), 64'd0);
        wr_cyc(ST_IDLE, 6'd40, 32'hBEEF);
        chk("wr_err_range", 64'(o_wr_err), 64'd1);
        cyc(ST_IDLE);
        chk("wr_err_clear2", 64'(o_wr_err), 64'd0);

        // Accepted write in INIT lands in set 3 bias.
        wr_cyc(ST_INIT, 6'd39, 32'd777);
        chk("wr_init_ok", 64'(o_wr_err), 64'd0);
        preload(2'd3);
        bias_exp(32'd777, 1'b1, 2'd3);
        cyc(ST_IDLE);

        // Readback of set 1 shows the rejected write left memory alone.
        preload(2'd1);
        for (int k = 0; k < 9; k++) shift_exp(32'(110 + k), 2'd1);
        cyc(ST_IDLE);

        // Reset in the middle of a SHIFT run.
        preload(2'd2);
        for (int k = 0; k < 3; k++) shift_exp(32'(120 + k), 2'd2);
        current_state = ST_SHIFT;
        #5;
        rst_n = 1'b0;
        #1;
        chk("async_weight", 64'(o_weight),       64'd0);
        chk("async_valid",  64'(o_weight_valid), 64'd0);
        chk("async_set",    64'(o_set_idx),      64'd0);
        current_state = ST_IDLE;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        shift_exp(32'd100, 2'd0);
        cyc(ST_IDLE);
        preload(2'd0);
        shift_exp(32'd100, 2'd0);
        cyc(ST_IDLE);
        cyc(ST_IDLE);
        cyc(ST_IDLE);

        chk("queue_drained", 64'(q.size()),  64'd0);
        chk("err_pulses",    64'(n_err_obs), 64'd2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
